// File: rtl/efferent_weight_bank.sv
// N x N sign-magnitude synapse weight store with a random-access port and a
// spike fan-out scan engine that streams one source row over valid/ready.
module efferent_weight_bank #(
  parameter int N_NEURONS = 4,
  parameter int WEIGHT_W  = 17,
  parameter int SKIP_ZERO = 0,
  localparam int TAG_W    = $clog2(N_NEURONS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                write_en,
  input  logic [TAG_W-1:0]    src_tag,
  input  logic [TAG_W-1:0]    dst_tag,
  input  logic [WEIGHT_W-1:0] weight_in,
  input  logic                read_en,
  output logic [WEIGHT_W-1:0] weight_out,
  input  logic                spike_valid,
  input  logic [TAG_W-1:0]    spike_src,
  output logic                spike_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [TAG_W-1:0]    out_dst,
  output logic [WEIGHT_W-1:0] out_weight,
  output logic                busy,
  output logic                scan_done
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  localparam logic [TAG_W:0]   LIMIT = (TAG_W + 1)'(N_NEURONS);
  localparam logic [TAG_W-1:0] LAST  = TAG_W'(N_NEURONS - 1);

  state_t              state, state_n;
  logic [WEIGHT_W-1:0] mem [N_NEURONS][N_NEURONS];
  logic [TAG_W-1:0]    scan_src, idx;
  logic                addr_ok, src_ok, idx_ok;
  logic                free, accept, examine, finish, emit;
  logic [WEIGHT_W-1:0] cur_w;

  assign addr_ok = ({1'b0, src_tag} < LIMIT) && ({1'b0, dst_tag} < LIMIT);
  assign src_ok  = {1'b0, scan_src} < LIMIT;
  assign idx_ok  = {1'b0, idx} < LIMIT;

  // Weight is sampled here, at the moment the entry is loaded into the beat register.
  assign cur_w = (src_ok && idx_ok) ? mem[scan_src][idx] : '0;
  assign emit  = src_ok && idx_ok && ((SKIP_ZERO == 0) || (cur_w[WEIGHT_W-2:0] != '0));
  assign free  = !out_valid || out_ready;

  assign spike_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        for (int unsigned j = 0; j < N_NEURONS; j++) begin
          mem[i][j] <= '0;
        end
      end
      weight_out <= '0;
    end else begin
      if (write_en && addr_ok) begin
        mem[src_tag][dst_tag] <= weight_in;
      end
      if (read_en) begin
        weight_out <= addr_ok ? mem[src_tag][dst_tag] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    examine = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        if (spike_valid) begin
          accept  = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (free) begin
          examine = 1'b1;
          if (idx == LAST) begin
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (free) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_dst    <= '0;
      out_weight <= '0;
      scan_done  <= 1'b0;
      scan_src   <= '0;
      idx        <= '0;
    end else begin
      scan_done <= finish;
      if (accept) begin
        scan_src <= spike_src;
        idx      <= '0;
      end
      // A skipped entry still frees the register if the held beat was just taken.
      if (examine) begin
        idx       <= idx + TAG_W'(1);
        out_valid <= emit;
        if (emit) begin
          out_dst    <= idx;
          out_weight <= cur_w;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
